// File: rtl/wb_noc_ni_master.sv
// wb_noc_ni_master: Wishbone slave that turns one transaction into a NoC request packet and completes it from the response.
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   wb_cyc_i/stb_i/we_i/addr_i/data_i/sel_i   Wishbone request from the core adapter (addr[31:28] = dest node)
//   wb_data_o, wb_ack_o, wb_err_o      registered read data, ack pulse, timeout pulse
//   flit_o, flit_valid_o, flit_ready_i request flits to the router
//   flit_i, flit_valid_i, flit_ready_o response flits from the router
module wb_noc_ni_master #(
    parameter logic [3:0] NODE_ID = 4'd0,
    parameter int         TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [33:0] flit_o,
    output logic        flit_valid_o,
    input  logic        flit_ready_i,
    input  logic [33:0] flit_i,
    input  logic        flit_valid_i,
    output logic        flit_ready_o
);
    typedef enum logic [3:0] {IDLE, TX_HEAD, TX_ADDR, TX_DATA, RX_HEAD, RX_DATA, DROP, ACK, ERR} state_t;
    state_t state, state_n;
    logic [31:0] addr_q, data_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [15:0] cnt;
    logic        tx_fire, rx_fire, rx_head, rx_tail, rsp_ok, timed_out, rx_state;
    assign tx_fire   = flit_valid_o & flit_ready_i;
    assign rx_fire   = flit_valid_i & flit_ready_o;
    assign rx_head   = flit_i[33:32] == 2'b01;
    assign rx_tail   = flit_i[33:32] == 2'b10;
    // A write completes on a single flit, a read starts with a head; anything else is foreign traffic.
    assign rsp_ok    = flit_i[31:28] == NODE_ID &&
                       (we_q ? (flit_i[33:32] == 2'b11 && flit_i[19:16] == 4'b1010)
                             : (rx_head && flit_i[19:16] == 4'b1001));
    assign timed_out = cnt == 16'(TIMEOUT - 1);
    assign rx_state  = state inside {RX_HEAD, RX_DATA, DROP};
    assign flit_ready_o = state == IDLE || rx_state;
    assign wb_ack_o  = state == ACK && wb_cyc_i;
    assign wb_err_o  = state == ERR && wb_cyc_i;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    // A valid completion wins over an expiring timeout in the same cycle.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (wb_cyc_i && wb_stb_i) state_n = TX_HEAD;
            TX_HEAD: if (tx_fire) state_n = TX_ADDR;
            TX_ADDR: if (tx_fire) state_n = we_q ? TX_DATA : RX_HEAD;
            TX_DATA: if (tx_fire) state_n = RX_HEAD;
            RX_HEAD: if (rx_fire && rsp_ok) state_n = we_q ? ACK : RX_DATA;
                     else if (timed_out) state_n = ERR;
                     else if (rx_fire && rx_head) state_n = DROP;
            RX_DATA: if (rx_fire && rx_tail) state_n = ACK;
                     else if (timed_out) state_n = ERR;
            DROP:    if (timed_out) state_n = ERR;
                     else if (rx_fire && rx_tail) state_n = RX_HEAD;
            default: state_n = IDLE;
        endcase
    end
    // Counter restarts whenever the block is outside the response phase, so RX_HEAD entry sees 0.
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt <= '0;
        else       cnt <= rx_state ? cnt + 16'd1 : '0;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            data_q       <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            flit_o       <= '0;
            flit_valid_o <= 1'b0;
            wb_data_o    <= '0;
        end else begin
            if (state == IDLE && wb_cyc_i && wb_stb_i) begin
                addr_q       <= wb_addr_i;
                data_q       <= wb_data_i;
                sel_q        <= wb_sel_i;
                we_q         <= wb_we_i;
                flit_o       <= {2'b01, wb_addr_i[31:28], NODE_ID, wb_sel_i, wb_we_i ? 4'b0010 : 4'b0001, 16'h0};
                flit_valid_o <= 1'b1;
            end
            if (state == TX_HEAD && tx_fire) flit_o <= {we_q ? 2'b00 : 2'b10, addr_q};
            if (state == TX_ADDR && tx_fire) begin
                flit_o       <= {2'b10, data_q};
                flit_valid_o <= we_q;
            end
            if (state == TX_DATA && tx_fire) flit_valid_o <= 1'b0;
            if (state == RX_DATA && rx_fire && rx_tail) wb_data_o <= flit_i[31:0];
        end
    end
endmodule

// File: tb/tb_wb_noc_ni_master.sv
// tb_wb_noc_ni_master: directed scoreboard bench for wb_noc_ni_master with NODE_ID=2, TIMEOUT=16.
module tb_wb_noc_ni_master;
    localparam logic [3:0] NODE = 4'd2;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_addr_i, wb_data_i, wb_data_o;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o, wb_err_o;
    logic [33:0] flit_o, flit_i;
    logic        flit_valid_o, flit_ready_i, flit_valid_i, flit_ready_o;
    int          n_tests = 0, n_fail = 0, cyc_n = 0, t_acc = 0, t_rx = 0;
    logic [33:0] exp_q[$];
    logic [31:0] exp_data = '0;

    wb_noc_ni_master #(.NODE_ID(NODE), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_sel_i(wb_sel_i),
        .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .flit_o(flit_o), .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready_i),
        .flit_i(flit_i), .flit_valid_i(flit_valid_i), .flit_ready_o(flit_ready_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_n++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_q.push_back({2'b01, a[31:28], NODE, s, we ? 4'h2 : 4'h1, 16'h0});
        exp_q.push_back({we ? 2'b00 : 2'b10, a});
        if (we) exp_q.push_back({2'b10, d});
    endtask

    task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_addr_i = a; wb_data_i = d; wb_sel_i = s;
        t_acc = cyc_n;
        tick;
    endtask

    // Pops each expected request flit as the DUT offers it; optional stall holds ready low.
    task automatic drain(input int stall);
        logic [33:0] f;
        while (exp_q.size() > 0) begin
            int b = 0;
            flit_ready_i = (stall == 0);
            while (!flit_valid_o && b < 40) begin tick; b++; end
            chk("req_valid", 64'(flit_valid_o), 64'(1));
            if (!flit_valid_o) begin exp_q.delete(); break; end
            f = flit_o;
            chk("req_flit", 64'(flit_o), 64'(exp_q.pop_front()));
            for (int i = 0; i < stall; i++) begin
                tick;
                chk("bp_stable", 64'(flit_o), 64'(f));
                chk("bp_valid", 64'(flit_valid_o), 64'(1));
            end
            flit_ready_i = 1'b1;
            tick;
        end
        flit_ready_i = 1'b1;
        t_rx = cyc_n;
    endtask

    task automatic send(input logic [33:0] f);
        int b = 0;
        flit_valid_i = 1'b1; flit_i = f;
        while (!flit_ready_o && b < 40) begin tick; b++; end
        chk("rsp_ready", 64'(flit_ready_o), 64'(1));
        tick;
        flit_valid_i = 1'b0; flit_i = '0;
    endtask

    task automatic wait_done(input string tag, input logic exp_ack, input int exp_lat, input int t0);
        int b = 0;
        while (!(wb_ack_o || wb_err_o) && b < 100) begin tick; b++; end
        chk({tag, "_ack"}, 64'(wb_ack_o), 64'(exp_ack));
        chk({tag, "_err"}, 64'(wb_err_o), 64'(!exp_ack));
        chk({tag, "_lat"}, 64'(cyc_n - t0), 64'(exp_lat));
        chk({tag, "_data"}, 64'(wb_data_o), 64'(exp_data));
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick;
        chk({tag, "_pulse"}, 64'(wb_ack_o | wb_err_o), 64'(0));
    endtask

    initial begin
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_addr_i = '0; wb_data_i = '0; wb_sel_i = '0;
        flit_ready_i = 1'b1; flit_valid_i = 1'b0; flit_i = '0;
        tick; tick;
        chk("rst_valid", 64'(flit_valid_o), 64'(0));
        chk("rst_flit", 64'(flit_o), 64'(0));
        chk("rst_ready", 64'(flit_ready_o), 64'(1));
        chk("rst_data", 64'(wb_data_o), 64'(0));
        chk("rst_ackerr", 64'({wb_ack_o, wb_err_o}), 64'(0));
        rst_i = 1'b0;
        tick;

        // Write with the literal flits from the test plan.
        exp_q.push_back({2'b01, 4'h3, 4'h2, 4'hF, 4'h2, 16'h0000});
        exp_q.push_back({2'b00, 32'h3000_0010});
        exp_q.push_back({2'b10, 32'hCAFE_BABE});
        req(1'b1, 32'h3000_0010, 32'hCAFE_BABE, 4'hF);
        drain(0);
        send({2'b11, 4'h2, 4'h3, 4'hF, 4'hA, 16'h0000});
        wait_done("write", 1'b1, 5, t_acc);

        // Read: head then tail with the data.
        push_req(1'b0, 32'h1000_0004, '0, 4'hF);
        req(1'b0, 32'h1000_0004, 32'h0, 4'hF);
        drain(0);
        send({2'b01, 4'h2, 4'h1, 4'hF, 4'h9, 16'h0000});
        chk("read_mid_noack", 64'(wb_ack_o), 64'(0));
        send({2'b10, 32'h1234_5678});
        exp_data = 32'h1234_5678;
        wb_done_read: wait_done("read", 1'b1, 5, t_acc);

        // Backpressure: 3 stalled cycles per request flit.
        push_req(1'b1, 32'h5000_0020, 32'hA5A5_0F0F, 4'h3);
        req(1'b1, 32'h5000_0020, 32'hA5A5_0F0F, 4'h3);
        drain(3);
        send({2'b11, 4'h2, 4'h5, 4'h3, 4'hA, 16'h0000});
        wait_done("bp", 1'b1, 14, t_acc);

        // Mismatch: a foreign three-flit packet is dropped, then the real response completes.
        push_req(1'b0, 32'h1000_0008, '0, 4'hF);
        req(1'b0, 32'h1000_0008, 32'h0, 4'hF);
        drain(0);
        send({2'b01, 4'h5, 4'h1, 4'hF, 4'h9, 16'h0000});
        chk("mm_noack_h", 64'(wb_ack_o), 64'(0));
        send({2'b00, 32'h1111_2222});
        chk("mm_noack_b", 64'(wb_ack_o), 64'(0));
        send({2'b10, 32'hDEAD_BEEF});
        chk("mm_noack_t", 64'(wb_ack_o), 64'(0));
        chk("mm_data_hold", 64'(wb_data_o), 64'(32'h1234_5678));
        send({2'b01, 4'h2, 4'h1, 4'hF, 4'h9, 16'h0000});
        send({2'b10, 32'h0BAD_F00D});
        exp_data = 32'h0BAD_F00D;
        wait_done("mismatch", 1'b1, 8, t_acc);

        // Timeout: no response, err 16 cycles after RX_HEAD entry, data unchanged.
        push_req(1'b0, 32'h7000_0000, '0, 4'h1);
        req(1'b0, 32'h7000_0000, 32'h0, 4'h1);
        drain(0);
        wait_done("timeout", 1'b0, 16, t_rx);
        send({2'b01, 4'h2, 4'h7, 4'h1, 4'h9, 16'h0000});
        send({2'b10, 32'hFEED_FACE});
        chk("late_noack", 64'(wb_ack_o), 64'(0));
        chk("late_idle_valid", 64'(flit_valid_o), 64'(0));
        chk("late_data_hold", 64'(wb_data_o), 64'(exp_data));
        push_req(1'b1, 32'h7000_0040, 32'h0000_00FF, 4'h1);
        req(1'b1, 32'h7000_0040, 32'h0000_00FF, 4'h1);
        drain(0);
        send({2'b11, 4'h2, 4'h7, 4'h1, 4'hA, 16'h0000});
        wait_done("after_to", 1'b1, 5, t_acc);

        // Asynchronous reset while in TX_ADDR.
        req(1'b1, 32'h9000_0000, 32'h1357_9BDF, 4'hF);
        tick;
        chk("pre_rst_flit", 64'(flit_o), 64'({2'b00, 32'h9000_0000}));
        #2 rst_i = 1'b1;
        #1;
        chk("arst_valid", 64'(flit_valid_o), 64'(0));
        chk("arst_flit", 64'(flit_o), 64'(0));
        chk("arst_ready", 64'(flit_ready_o), 64'(1));
        chk("arst_data", 64'(wb_data_o), 64'(0));
        chk("arst_ackerr", 64'({wb_ack_o, wb_err_o}), 64'(0));
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        exp_data = '0;
        tick; tick;
        rst_i = 1'b0;
        tick;
        push_req(1'b0, 32'h1000_0004, '0, 4'hF);
        req(1'b0, 32'h1000_0004, 32'h0, 4'hF);
        drain(0);
        send({2'b01, 4'h2, 4'h1, 4'hF, 4'h9, 16'h0000});
        send({2'b10, 32'h55AA_55AA});
        exp_data = 32'h55AA_55AA;
        wait_done("post_rst", 1'b1, 5, t_acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
